// File: rtl/fc_pkg.sv
// Shared FSM encoding, widths and defaults for the servo pulse sequencer.
// No timing of its own; the clamp helper is purely combinational.
package fc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_EMIT    = 2'd2
    } state_t;

    localparam int          DEF_SHIFT   = 5;
    localparam logic [23:0] DEF_TIMEOUT = 24'd3200000;
    localparam int          CNT_W       = 16;
    localparam int          WD_W        = 24;
    localparam int          DATA_W      = 10;

    // Negative results floor at 0, anything past the 10-bit range pins to full scale.
    function automatic logic [DATA_W-1:0] clamp_cmd(input logic signed [16:0] val);
        logic [DATA_W-1:0] res;
        if (val[16]) begin
            res = '0;
        end else if (val[15:DATA_W] != '0) begin
            res = '1;
        end else begin
            res = val[DATA_W-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/servo_edge_sync.sv
// Four-stage synchroniser for one servo line; rise/fall strobes compare stages 3 and 2 (3-cycle latency).
// Strobes stay off until stage 3 holds a post-reset sample, so a line held high through reset is not an edge.
module servo_edge_sync (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_din,
    output logic o_lvl,
    output logic o_rise,
    output logic o_fall
);

    logic [3:0] r_sync;
    logic [3:0] r_vld;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync <= '0;
            r_vld  <= '0;
        end else begin
            r_sync <= {r_sync[2:0], i_din};
            r_vld  <= {r_vld[2:0], 1'b1};
        end
    end

    assign o_lvl  = r_sync[2];
    assign o_rise = r_vld[3] &  r_sync[2] & ~r_sync[3];
    assign o_fall = r_vld[3] & ~r_sync[2] &  r_sync[3];

endmodule

// File: rtl/servo_sequencer.sv
// Measures one servo pulse at a time, subtracts a per-channel offset and presents a clamped 10-bit command.
// Command sits on CMD_VALID/CMD_DATA until CMD_READY; pulses arriving while busy are dropped and flagged.
module servo_sequencer
    import fc_pkg::*;
#(
    parameter int          NCH     = 4,
    parameter int          SHIFT   = DEF_SHIFT,
    parameter logic [23:0] TIMEOUT = DEF_TIMEOUT
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic [NCH-1:0] SERVO,
    input  logic           CFG_WE,
    input  logic [1:0]     CFG_ADDR,
    input  logic [9:0]     CFG_DATA,
    output logic           CMD_VALID,
    input  logic           CMD_READY,
    output logic [1:0]     CMD_CH,
    output logic [9:0]     CMD_DATA,
    output logic           FRAME,
    output logic           OVERLAP,
    output logic           FAILSAFE
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [NCH-1:0]      w_lvl;
    logic [NCH-1:0]      w_rise;
    logic [NCH-1:0]      w_fall;
    logic [CNT_W-1:0]    r_cnt;
    logic [WD_W-1:0]     r_wd;
    logic [DATA_W-1:0]   r_offset [NCH];
    logic [1:0]          r_ch;
    logic [1:0]          r_cmd_ch;
    logic [DATA_W-1:0]   r_cmd_data;
    logic                r_ovl;
    logic                r_frame;
    logic                w_lock;
    logic [1:0]          w_lock_ch;
    logic                w_load;
    logic                w_drop;
    logic                w_accept;
    logic signed [16:0]  w_diff;

    for (genvar gi = 0; gi < NCH; gi++) begin : g_sync
        servo_edge_sync u_sync (
            .i_clk  (CLK),
            .i_rst  (RST),
            .i_din  (SERVO[gi]),
            .o_lvl  (w_lvl[gi]),
            .o_rise (w_rise[gi]),
            .o_fall (w_fall[gi])
        );
    end

    assign w_accept = (r_state == ST_EMIT) && CMD_READY;
    assign w_diff   = $signed({1'b0, r_cnt >> SHIFT}) - $signed({7'b0, r_offset[r_ch]});

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_lock      = 1'b0;
        w_lock_ch   = '0;
        w_load      = 1'b0;
        w_drop      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Lowest index wins a simultaneous start; the losers are dropped.
                for (int i = 0; i < NCH; i++) begin
                    if (w_rise[i]) begin
                        if (w_lock) begin
                            w_drop = 1'b1;
                        end else begin
                            w_lock    = 1'b1;
                            w_lock_ch = 2'(i);
                        end
                    end
                end
                if (w_lock) begin
                    w_state_nxt = ST_MEASURE;
                end
            end
            ST_MEASURE: begin
                if (w_fall[r_ch]) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (CMD_READY) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        if (r_state != ST_IDLE) begin
            for (int i = 0; i < NCH; i++) begin
                if (w_rise[i] && (2'(i) != r_ch)) begin
                    w_drop = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cnt      <= '0;
            r_ch       <= '0;
            r_cmd_ch   <= '0;
            r_cmd_data <= '0;
            r_ovl      <= 1'b0;
            r_frame    <= 1'b0;
            r_wd       <= '0;
            for (int i = 0; i < NCH; i++) begin
                r_offset[i] <= '0;
            end
        end else begin
            // The rise cycle is already the first high cycle, so the count starts at 1.
            if (w_lock) begin
                r_ch  <= w_lock_ch;
                r_cnt <= CNT_W'(1);
            end else if ((r_state == ST_MEASURE) && w_lvl[r_ch] && (r_cnt != '1)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_load) begin
                r_cmd_ch   <= r_ch;
                r_cmd_data <= clamp_cmd(w_diff);
            end
            if (w_drop) begin
                r_ovl <= 1'b1;
            end
            r_frame <= w_accept && (32'(r_cmd_ch) == NCH - 1);
            if (w_accept) begin
                r_wd <= '0;
            end else if (r_wd != '1) begin
                r_wd <= r_wd + WD_W'(1);
            end
            if (CFG_WE && (32'(CFG_ADDR) < NCH)) begin
                r_offset[CFG_ADDR] <= CFG_DATA;
            end
        end
    end

    assign CMD_VALID = (r_state == ST_EMIT);
    assign CMD_CH    = r_cmd_ch;
    assign CMD_DATA  = r_cmd_data;
    assign FRAME     = r_frame;
    assign OVERLAP   = r_ovl;
    assign FAILSAFE  = (r_wd >= TIMEOUT);

endmodule

// File: tb/tb_servo_sequencer.sv
// Directed bench for servo_sequencer: vector table of single pulses plus hand sequences for reset, overlap, stall and failsafe.
// DUT runs with SHIFT=1 and TIMEOUT=1000 so the long-pulse cases stay short.
module tb_servo_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] servo;
    logic       cfg_we;
    logic [1:0] cfg_addr;
    logic [9:0] cfg_data;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_ch;
    logic [9:0] cmd_data;
    logic       frame;
    logic       overlap;
    logic       failsafe;

    int n_tests = 0;
    int n_fail  = 0;
    int frame_cnt = 0;

    typedef struct {
        logic [1:0] ch;
        int         width;
        logic [9:0] offset;
        logic [9:0] exp_data;
    } vec_t;

    vec_t vecs [8];

    always #5 clk = ~clk;

    servo_sequencer #(
        .NCH     (4),
        .SHIFT   (1),
        .TIMEOUT (24'd1000)
    ) dut (
        .CLK       (clk),
        .RST       (rst),
        .SERVO     (servo),
        .CFG_WE    (cfg_we),
        .CFG_ADDR  (cfg_addr),
        .CFG_DATA  (cfg_data),
        .CMD_VALID (cmd_valid),
        .CMD_READY (cmd_ready),
        .CMD_CH    (cmd_ch),
        .CMD_DATA  (cmd_data),
        .FRAME     (frame),
        .OVERLAP   (overlap),
        .FAILSAFE  (failsafe)
    );

    always @(negedge clk) begin
        if (frame) frame_cnt <= frame_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic write_offset(input logic [1:0] ch, input logic [9:0] val);
        @(negedge clk);
        cfg_we   = 1'b1;
        cfg_addr = ch;
        cfg_data = val;
        @(negedge clk);
        cfg_we   = 1'b0;
    endtask

    task automatic drive_pulse(input logic [1:0] ch, input int width);
        @(negedge clk);
        servo[ch] = 1'b1;
        repeat (width) @(negedge clk);
        servo[ch] = 1'b0;
    endtask

    task automatic wait_valid(input string name, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cmd_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: CMD_VALID not seen within 20 cycles, required 1", name);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: bench still running, required to finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        bit ok;
        bit extra;
        bit stable;
        int frame_base;

        vecs[0] = '{2'd0, 2000,  10'd0,   10'd1000};
        vecs[1] = '{2'd1, 600,   10'd200, 10'd100};
        vecs[2] = '{2'd1, 600,   10'd400, 10'd0};
        vecs[3] = '{2'd3, 2050,  10'd0,   10'd1023};
        vecs[4] = '{2'd2, 201,   10'd0,   10'd100};
        vecs[5] = '{2'd0, 2,     10'd1,   10'd0};
        vecs[6] = '{2'd3, 130,   10'd5,   10'd60};
        vecs[7] = '{2'd2, 65600, 10'd0,   10'd1023};

        rst = 1'b1; servo = '0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; cmd_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_valid",    cmd_valid, 0);
        check("rst_ch",       cmd_ch,    0);
        check("rst_data",     cmd_data,  0);
        check("rst_frame",    frame,     0);
        check("rst_overlap",  overlap,   0);
        check("rst_failsafe", failsafe,  0);
        rst = 1'b0;

        // Watchdog: 999 idle edges keep FAILSAFE low, the 1000th raises it.
        repeat (999) @(negedge clk);
        check("failsafe_999", failsafe, 0);
        @(negedge clk);
        check("failsafe_1000", failsafe, 1);
        drive_pulse(2'd0, 40);
        wait_valid("fs_cmd", ok);
        if (ok) begin
            check("fs_cmd_data", cmd_data, 20);
            check("fs_before_accept", failsafe, 1);
            @(negedge clk);
            check("fs_after_accept", failsafe, 0);
        end
        repeat (3) @(negedge clk);

        for (int k = 0; k < 8; k++) begin
            write_offset(vecs[k].ch, vecs[k].offset);
            drive_pulse(vecs[k].ch, vecs[k].width);
            wait_valid($sformatf("vec%0d_valid", k), ok);
            if (ok) begin
                check($sformatf("vec%0d_ch", k),   cmd_ch,   vecs[k].ch);
                check($sformatf("vec%0d_data", k), cmd_data, vecs[k].exp_data);
            end
            repeat (3) @(negedge clk);
        end
        check("table_overlap_clear", overlap, 0);

        // Simultaneous rise on ch0 and ch3: ch0 wins, ch3 is dropped and flagged.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        servo[0] = 1'b1;
        servo[3] = 1'b1;
        repeat (100) @(negedge clk);
        servo[3] = 1'b0;
        repeat (100) @(negedge clk);
        servo[0] = 1'b0;
        wait_valid("ovl_valid", ok);
        if (ok) begin
            check("ovl_ch",   cmd_ch,   0);
            check("ovl_data", cmd_data, 100);
            check("ovl_flag", overlap,  1);
        end
        extra = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (cmd_valid) extra = 1'b1;
        end
        check("ovl_no_ch3_cmd", extra, 0);
        check("ovl_sticky", overlap, 1);
        rst = 1'b1;
        @(negedge clk);
        check("ovl_cleared_by_rst", overlap, 0);
        rst = 1'b0;

        // Reset in the middle of a pulse: the rest of that pulse must not produce a command.
        @(negedge clk);
        servo[1] = 1'b1;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (50) @(negedge clk);
        servo[1] = 1'b0;
        extra = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (cmd_valid) extra = 1'b1;
        end
        check("rst_midpulse_discard", extra, 0);
        drive_pulse(2'd1, 20);
        wait_valid("fresh_after_rst", ok);
        if (ok) check("fresh_after_rst_data", cmd_data, 10);
        repeat (3) @(negedge clk);

        // Reset while a command is waiting for READY.
        cmd_ready = 1'b0;
        drive_pulse(2'd2, 60);
        wait_valid("midemit_valid", ok);
        if (ok) check("midemit_data", cmd_data, 30);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midemit_rst_valid", cmd_valid, 0);
        check("midemit_rst_data",  cmd_data,  0);
        check("midemit_rst_ch",    cmd_ch,    0);
        rst = 1'b0;
        extra = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (cmd_valid) extra = 1'b1;
        end
        check("midemit_discarded", extra, 0);
        cmd_ready = 1'b1;

        // Frame sequence ch0..ch3 with a 50-cycle stall on ch2.
        frame_base = frame_cnt;
        for (int c = 0; c < 2; c++) begin
            drive_pulse(2'(c), 40);
            wait_valid($sformatf("seq%0d_valid", c), ok);
            if (ok) begin
                check($sformatf("seq%0d_ch", c),   cmd_ch,   c);
                check($sformatf("seq%0d_data", c), cmd_data, 20);
            end
            repeat (3) @(negedge clk);
        end
        cmd_ready = 1'b0;
        drive_pulse(2'd2, 40);
        wait_valid("seq2_valid", ok);
        if (ok) begin
            stable = 1'b1;
            repeat (50) begin
                @(negedge clk);
                if (!cmd_valid || (cmd_data != 10'd20) || (cmd_ch != 2'd2)) stable = 1'b0;
            end
            check("seq2_stall_stable", stable, 1);
        end
        cmd_ready = 1'b1;
        @(negedge clk);
        check("seq2_released", cmd_valid, 0);
        repeat (3) @(negedge clk);
        check("seq_no_early_frame", frame_cnt - frame_base, 0);
        drive_pulse(2'd3, 40);
        wait_valid("seq3_valid", ok);
        if (ok) begin
            check("seq3_ch", cmd_ch, 3);
            check("seq3_frame_before", frame, 0);
            @(negedge clk);
            check("seq3_frame_pulse", frame, 1);
            @(negedge clk);
            check("seq3_frame_after", frame, 0);
        end
        repeat (3) @(negedge clk);
        check("seq_frame_count", frame_cnt - frame_base, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
